// File: rtl/foc_pkg.sv
// Shared types and Q-format constants for the FOC current-loop datapath.
package foc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAG,
    DIV,
    SCALE,
    DONE
  } limiter_state_t;

  // Default Q4.12 sample format.
  localparam int unsigned Q_FRAC = 12;
  localparam int unsigned ONE    = 1 << Q_FRAC;

  // 1/K of the CORDIC vectoring gain (K ~= 1.646760258) in Q0.20.
  localparam int unsigned CORDIC_KINV_SHIFT = 20;
  localparam int unsigned CORDIC_KINV       = 636751;

endpackage

// File: rtl/magnitude.sv
// Combinational CORDIC vectoring magnitude: mag ~= sqrt(x^2 + y^2), gain-compensated.
module magnitude
  import foc_pkg::*;
#(
  parameter int WIDTH           = 17,
  parameter int FRACTIONAL_BITS = 12,
  parameter int ITERATIONS      = 16
) (
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] mag
);

  // Guard bits below the sample LSB keep per-iteration shift truncation
  // from accumulating into the result.
  localparam int GUARD = FRACTIONAL_BITS / 2;
  localparam int IW    = WIDTH + 3 + GUARD;
  localparam int PW    = IW + int'(CORDIC_KINV_SHIFT) + 1;
  localparam int OSH   = int'(CORDIC_KINV_SHIFT) + GUARD;

  logic signed [IW-1:0] xs, ys, x, y, xn, yn;
  logic        [PW-1:0] prod;

  // Rotate the vector onto the positive x axis, then remove the CORDIC gain with rounding.
  always_comb begin
    xs = IW'($signed(x_in));
    ys = IW'($signed(y_in));
    x  = (xs[IW-1] ? -xs : xs) <<< GUARD;
    y  = ys <<< GUARD;
    xn = x;
    yn = y;
    for (int unsigned i = 0; i < ITERATIONS; i++) begin
      if (y[IW-1]) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
      end
      x = xn;
      y = yn;
    end
    prod = PW'(unsigned'(x)) * PW'(CORDIC_KINV) + (PW'(1) << (OSH - 1));
    mag  = WIDTH'(prod >> OSH);
  end

endmodule

// File: rtl/vector_limiter.sv
// Circular voltage limiter: rescales (d, q) by vmax/|v| when |v| exceeds vmax.
module vector_limiter
  import foc_pkg::*;
#(
  parameter int WIDTH           = 17,
  parameter int FRACTIONAL_BITS = 12,
  parameter int ITERATIONS      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] vmax,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] mag_out,
  output logic             limited
);

  localparam int CW = (FRACTIONAL_BITS > 1) ? $clog2(FRACTIONAL_BITS) : 1;
  localparam int PW = 2 * WIDTH;

  limiter_state_t state, state_nx;

  logic [WIDTH-1:0]           d_r, q_r, vmax_r, mag_w;
  logic [WIDTH:0]             rem, rem_sh, rem_nx;
  logic [FRACTIONAL_BITS-1:0] ratio;
  logic [CW-1:0]              cnt;
  logic                       q_bit;
  logic                       accept;
  logic                       fits;
  logic signed [PW-1:0]       ratio_s, d_prod, q_prod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign fits      = (mag_w <= vmax_r);

  magnitude #(
    .WIDTH          (WIDTH),
    .FRACTIONAL_BITS(FRACTIONAL_BITS),
    .ITERATIONS     (ITERATIONS)
  ) u_mag (
    .x_in(d_r),
    .y_in(q_r),
    .mag (mag_w)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAG;
      MAG:     state_nx = fits ? DONE : DIV;
      DIV:     if (cnt == '0) state_nx = SCALE;
      SCALE:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One restoring-division step; rem < mag always holds, so the shift cannot overflow.
  always_comb begin
    rem_sh = rem << 1;
    q_bit  = (rem_sh >= {1'b0, mag_out});
    rem_nx = q_bit ? (rem_sh - {1'b0, mag_out}) : rem_sh;
  end

  // Signed scaling products with the unsigned ratio zero-extended.
  always_comb begin
    ratio_s = $signed({{(PW-FRACTIONAL_BITS){1'b0}}, ratio});
    d_prod  = PW'($signed(d_r)) * ratio_s;
    q_prod  = PW'($signed(q_r)) * ratio_s;
  end

  // Datapath registers: input latch, magnitude capture, divider and output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r     <= '0;
      q_r     <= '0;
      vmax_r  <= '0;
      mag_out <= '0;
      rem     <= '0;
      ratio   <= '0;
      cnt     <= '0;
      d_out   <= '0;
      q_out   <= '0;
      limited <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_r    <= d_in;
            q_r    <= q_in;
            vmax_r <= vmax;
          end
        end
        MAG: begin
          mag_out <= mag_w;
          if (fits) begin
            d_out   <= d_r;
            q_out   <= q_r;
            limited <= 1'b0;
          end else begin
            rem   <= {1'b0, vmax_r};
            ratio <= '0;
            cnt   <= CW'(FRACTIONAL_BITS - 1);
          end
        end
        DIV: begin
          rem   <= rem_nx;
          ratio <= {ratio[FRACTIONAL_BITS-2:0], q_bit};
          cnt   <= cnt - CW'(1);
        end
        SCALE: begin
          d_out   <= WIDTH'(d_prod >>> FRACTIONAL_BITS);
          q_out   <= WIDTH'(q_prod >>> FRACTIONAL_BITS);
          limited <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_limiter.sv
// Self-checking bench for vector_limiter against a real-arithmetic reference.
module tb_vector_limiter;

  localparam int W = 17;
  localparam int F = 12;
  localparam int LAT_PASS = 2;
  localparam int LAT_LIM  = F + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_in, q_in, vmax;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out, q_out, mag_out;
  logic         limited;

  int total = 0;
  int bad   = 0;

  vector_limiter #(
    .WIDTH          (W),
    .FRACTIONAL_BITS(F),
    .ITERATIONS     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d_in     (d_in),
    .q_in     (q_in),
    .vmax     (vmax),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d_out    (d_out),
    .q_out    (q_out),
    .mag_out  (mag_out),
    .limited  (limited)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  function automatic real true_mag(input int d, input int q);
    real rd, rq;
    rd = d;
    rq = q;
    return $sqrt(rd * rd + rq * rq);
  endfunction

  function automatic int sv(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  // Presents one vector, waits (bounded) for out_valid; lat counts edges from acceptance.
  task automatic send(input int d, input int q, input int vm, output int lat);
    @(negedge clk);
    d_in     = W'(d);
    q_in     = W'(q);
    vmax     = W'(vm);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    d_in = '0; q_in = '0; vmax = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (d_out !== '0) begin bad++; $display("FAIL reset_d_out got=%0d want=0", d_out); end
    total++; if (q_out !== '0) begin bad++; $display("FAIL reset_q_out got=%0d want=0", q_out); end
    total++; if (mag_out !== '0) begin bad++; $display("FAIL reset_mag_out got=%0d want=0", mag_out); end
    total++; if (limited !== 1'b0) begin bad++; $display("FAIL reset_limited got=%0b want=0", limited); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    int lat;
    send(2458, 3277, 4096, lat);
    total++; if (lat != LAT_PASS) begin bad++; $display("FAIL pass_latency got=%0d want=%0d", lat, LAT_PASS); end
    total++; if (sv(d_out) != 2458) begin bad++; $display("FAIL pass_d got=%0d want=2458", sv(d_out)); end
    total++; if (sv(q_out) != 3277) begin bad++; $display("FAIL pass_q got=%0d want=3277", sv(q_out)); end
    total++; if (limited !== 1'b0) begin bad++; $display("FAIL pass_limited got=%0b want=0", limited); end
    total++; if (rabs(real'(int'(mag_out)) - true_mag(2458, 3277)) > 2.0) begin bad++; $display("FAIL pass_mag got=%0d want~%0f", mag_out, true_mag(2458, 3277)); end
    handshake();
  endtask

  task automatic check_limit(input int d, input int q, input int ed, input int eq, input string tag);
    int lat;
    send(d, q, 10240, lat);
    total++; if (lat != LAT_LIM) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", tag, lat, LAT_LIM); end
    total++; if (limited !== 1'b1) begin bad++; $display("FAIL %s_limited got=%0b want=1", tag, limited); end
    total++; if (rabs(real'(int'(mag_out)) - 20480.0) > 2.0) begin bad++; $display("FAIL %s_mag got=%0d want~20480", tag, mag_out); end
    total++; if (rabs(real'(sv(d_out) - ed)) > 2.0) begin bad++; $display("FAIL %s_d got=%0d want~%0d", tag, sv(d_out), ed); end
    total++; if (rabs(real'(sv(q_out) - eq)) > 2.0) begin bad++; $display("FAIL %s_q got=%0d want~%0d", tag, sv(q_out), eq); end
    handshake();
  endtask

  task automatic test_limit();
    check_limit(12288, 16384, 6144, 8192, "limit");
  endtask

  task automatic test_sign();
    check_limit(-12288, 16384, -6144, 8192, "sign");
    check_limit(12288, -16384, 6144, -8192, "sign_q");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] hd, hq, hm;
    send(1000, -2000, 30000, lat);
    hd = d_out; hq = q_out; hm = mag_out;
    total++; if (sv(hd) != 1000) begin bad++; $display("FAIL bp_first_d got=%0d want=1000", sv(hd)); end
    @(negedge clk);
    d_in = W'(-3000); q_in = W'(500); vmax = W'(30000);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got valid=%0b ready=%0b want valid=1 ready=0", i, out_valid, in_ready); end
      total++; if (d_out !== hd || q_out !== hq || mag_out !== hm) begin bad++; $display("FAIL bp_stable%0d got d=%0d q=%0d want d=%0d q=%0d", i, sv(d_out), sv(q_out), sv(hd), sv(hq)); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got ready=%0b want=0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++; if (lat != LAT_PASS) begin bad++; $display("FAIL bp_second_latency got=%0d want=%0d", lat, LAT_PASS); end
    total++; if (sv(d_out) != -3000 || sv(q_out) != 500) begin bad++; $display("FAIL bp_second got d=%0d q=%0d want d=-3000 q=500", sv(d_out), sv(q_out)); end
    handshake();
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    d_in = W'(12288); q_in = W'(16384); vmax = W'(10240);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || d_out !== '0 || q_out !== '0 || mag_out !== '0 || limited !== 1'b0) begin
      bad++; $display("FAIL middiv_reset got valid=%0b d=%0d q=%0d mag=%0d lim=%0b want all 0", out_valid, d_out, q_out, mag_out, limited);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL middiv_ready got=%0b want=1", in_ready); end
    check_limit(-12288, -16384, -6144, -8192, "after_reset");
  endtask

  task automatic test_edges();
    int lat;
    send(4096, 0, 0, lat);
    total++; if (lat != LAT_LIM) begin bad++; $display("FAIL vmax0_latency got=%0d want=%0d", lat, LAT_LIM); end
    total++; if (d_out !== '0 || q_out !== '0 || limited !== 1'b1) begin bad++; $display("FAIL vmax0 got d=%0d q=%0d lim=%0b want 0 0 1", sv(d_out), sv(q_out), limited); end
    handshake();
    send(0, 0, 0, lat);
    total++; if (lat != LAT_PASS) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT_PASS); end
    total++; if (d_out !== '0 || q_out !== '0 || mag_out !== '0 || limited !== 1'b0) begin bad++; $display("FAIL zero got d=%0d q=%0d mag=%0d lim=%0b want 0 0 0 0", sv(d_out), sv(q_out), mag_out, limited); end
    handshake();
  endtask

  task automatic test_random();
    int d, q, vm, lat;
    real m, ed, eq, tol;
    bit lim;
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 131071)) - 65536;
      q = int'($urandom_range(0, 131071)) - 65536;
      m = true_mag(d, q);
      do begin
        vm = int'($urandom_range(0, 100000));
      end while (rabs(real'(vm) - m) <= 3.0);
      lim = (m > real'(vm));
      send(d, q, vm, lat);
      total++; if (lat != (lim ? LAT_LIM : LAT_PASS)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, lim ? LAT_LIM : LAT_PASS); end
      total++; if (limited !== lim) begin bad++; $display("FAIL rnd%0d_limited got=%0b want=%0b", n, limited, lim); end
      total++; if (rabs(real'(int'(mag_out)) - m) > 2.0) begin bad++; $display("FAIL rnd%0d_mag got=%0d want~%0f", n, mag_out, m); end
      if (lim) begin
        ed  = real'(d) * real'(vm) / m;
        eq  = real'(q) * real'(vm) / m;
        tol = 4.0 + rabs(real'(d) > rabs(real'(q)) ? real'(d) : real'(q)) / 4096.0;
        total++; if (rabs(real'(sv(d_out)) - ed) > tol || rabs(real'(sv(q_out)) - eq) > tol) begin
          bad++; $display("FAIL rnd%0d_scaled got d=%0d q=%0d want~%0f %0f", n, sv(d_out), sv(q_out), ed, eq);
        end
      end else begin
        total++; if (sv(d_out) != d || sv(q_out) != q) begin bad++; $display("FAIL rnd%0d_pass got d=%0d q=%0d want d=%0d q=%0d", n, sv(d_out), sv(q_out), d, q); end
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_limit();
    test_sign();
    test_backpressure();
    test_reset_mid_div();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
